// File: rtl/rocc_cmd_arbiter.sv
// rocc_cmd_arbiter: round-robin scheduler sharing one rocc_accel between
// NUM_REQ command sources. One command in flight at a time; the owner gets a
// one-cycle resp_valid pulse carrying rd when the accelerator goes idle again.
// Optional watchdog: define ROCC_ARB_WDOG_EN to abort stuck ISSUE/BUSY phases
// after TIMEOUT_CYCLES and pulse err.
module rocc_cmd_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int INST_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*(INST_WIDTH-5)-1:0]   req_inst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_rs1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_rs2,
  output logic [INST_WIDTH-6:0]               acc_inst,
  output logic [DATA_WIDTH-1:0]               acc_rs1,
  output logic [DATA_WIDTH-1:0]               acc_rs2,
  output logic                                acc_valid,
  input  logic                                acc_ready,
  output logic [NUM_REQ-1:0]                  resp_valid,
  output logic [4:0]                          resp_rd,
  output logic                                busy,
  output logic                                err
);
  localparam int CW = INST_WIDTH - 5;
  localparam int GW = $clog2(NUM_REQ);
  localparam logic [GW:0] NR_W = (GW+1)'(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("rocc_cmd_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t            state, state_ev, state_nx;
  logic [GW-1:0]     last_grant, owner, winner;
  logic [GW:0]       cand;
  logic              win_found, transfer, complete;
  logic [CW-1:0]     sel_inst;
  logic [DATA_WIDTH-1:0] sel_rs1, sel_rs2;

  // Round-robin search starting just after the last grant, wrapping at NUM_REQ
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + (GW+1)'(k);
      if (cand >= NR_W) cand = cand - NR_W;
      if (!win_found && req_valid[cand[GW-1:0]]) begin
        win_found = 1'b1;
        winner    = cand[GW-1:0];
      end
    end
  end

  // Payload mux for the current winner
  always_comb begin
    sel_inst = '0;
    sel_rs1  = '0;
    sel_rs2  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == GW'(i)) begin
        sel_inst = req_inst[i*CW +: CW];
        sel_rs1  = req_rs1[i*DATA_WIDTH +: DATA_WIDTH];
        sel_rs2  = req_rs2[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign transfer  = (state == IDLE) && win_found && acc_ready;
  assign complete  = (state == BUSY) && acc_ready;
  assign req_ready = transfer ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << winner) : '0;
  assign acc_valid = (state == ISSUE);
  assign busy      = (state != IDLE);

  // Handshake-driven next state; ready low in ISSUE means the command was taken
  always_comb begin
    state_ev = state;
    case (state)
      IDLE:    if (transfer)   state_ev = ISSUE;
      ISSUE:   if (!acc_ready) state_ev = BUSY;
      BUSY:    if (acc_ready)  state_ev = IDLE;
      default: state_ev = IDLE;
    endcase
  end

`ifdef ROCC_ARB_WDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_cnt;
  logic          timeout;

  // A normal transition in the same cycle wins over the timeout
  assign timeout  = (state != IDLE) && (state_ev == state) &&
                    (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
  assign state_nx = timeout ? IDLE : state_ev;

  // Watchdog counts dwell cycles in ISSUE/BUSY, cleared on any state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      err <= timeout;
      if (state_nx != state || state == IDLE) wd_cnt <= '0;
      else                                    wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign state_nx = state_ev;
  assign err      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Capture the granted command; payload only moves on a transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_inst   <= '0;
      acc_rs1    <= '0;
      acc_rs2    <= '0;
      owner      <= '0;
      last_grant <= GW'(NUM_REQ - 1);
    end else if (transfer) begin
      acc_inst   <= sel_inst;
      acc_rs1    <= sel_rs1;
      acc_rs2    <= sel_rs2;
      owner      <= winner;
      last_grant <= winner;
    end
  end

  // Completion pulse to the owner; resp_rd holds until the next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= '0;
      resp_rd    <= '0;
    end else begin
      resp_valid <= complete ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner) : '0;
      if (complete) resp_rd <= acc_inst[6:2];
    end
  end

endmodule

// File: tb/tb_rocc_cmd_arbiter.sv
// Bench for rocc_cmd_arbiter: directed scenarios plus randomized traffic,
// checked each cycle against a transaction-level reference model.
module tb_rocc_cmd_arbiter;
  localparam int NR = 4;
  localparam int CW = 27;
  localparam int DW = 64;

  logic              clk, rst_n;
  logic [NR-1:0]     req_valid, req_ready, resp_valid;
  logic [NR*CW-1:0]  req_inst;
  logic [NR*DW-1:0]  req_rs1, req_rs2;
  logic [CW-1:0]     acc_inst;
  logic [DW-1:0]     acc_rs1, acc_rs2;
  logic              acc_valid, acc_ready, busy, err;
  logic [4:0]        resp_rd;

  rocc_cmd_arbiter #(.NUM_REQ(NR), .INST_WIDTH(32), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_inst(req_inst), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .acc_inst(acc_inst), .acc_rs1(acc_rs1), .acc_rs2(acc_rs2),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .resp_valid(resp_valid),
    .resp_rd(resp_rd), .busy(busy), .err(err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int npass = 0, nchk = 0, nfail = 0;

  // Reference model: one command outstanding, presented until ready drops,
  // then in flight until ready rises again.
  bit            m_busy, m_presented;
  int            m_owner, m_last;
  logic [CW-1:0] m_inst;
  logic [DW-1:0] m_rs1, m_rs2;
  logic [4:0]    m_rd;

  // Stimulus state
  bit accel_auto, rand_lat, rand_glitch, rand_req;
  int acc_cnt, fix_lat;
  int remain [NR];
  logic [NR-1:0] xfer;
  int grants[$];
  int rd_log[$];
  int resp_cnt [NR];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  function automatic logic [CW-1:0] mk_inst(input int rd);
    logic [4:0] r1, r2, d;
    r1 = 5'($urandom);
    r2 = 5'($urandom);
    d  = 5'(rd);
    return {7'h01, r2, r1, 3'b011, d, 2'b00};
  endfunction

  task automatic load(input int i);
    req_inst[CW*i +: CW] = mk_inst(i + 1);
    req_rs1[DW*i +: DW]  = {$urandom, $urandom};
    req_rs2[DW*i +: DW]  = {$urandom, $urandom};
  endtask

  task automatic start_req(input int i, input int n);
    req_valid[i] = 1'b1;
    load(i);
    remain[i] = n - 1;
  endtask

  task automatic m_reset();
    m_busy = 0; m_presented = 0; m_owner = 0; m_last = NR - 1;
    m_inst = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
  endtask

  // Asserted at a negedge; outputs must clear without waiting for a clock
  task automatic apply_reset();
    req_valid = '0; acc_ready = 1'b1; acc_cnt = 0;
    rand_req = 0; rand_glitch = 0; rand_lat = 0; accel_auto = 1;
    for (int i = 0; i < NR; i++) begin remain[i] = 0; resp_cnt[i] = 0; end
    rst_n = 1'b0;
    #1;
    m_reset();
    grants.delete(); rd_log.delete();
    chk("rst_acc_valid", 64'(acc_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_acc_inst", 64'(acc_inst), 64'(0));
    chk("rst_acc_rs1", acc_rs1, 64'(0));
    chk("rst_acc_rs2", acc_rs2, 64'(0));
    chk("rst_resp_rd", 64'(resp_rd), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_accel();
    if (!accel_auto) return;
    if (acc_cnt > 0) begin
      acc_cnt--;
      if (acc_cnt == 0) acc_ready = 1'b1;
    end else if (acc_ready && acc_valid) begin
      acc_ready = 1'b0;
      acc_cnt   = rand_lat ? int'($urandom_range(1, 6)) : fix_lat;
    end else if (acc_ready && !busy && rand_glitch && $urandom_range(9) == 0) begin
      acc_ready = 1'b0;
      acc_cnt   = 1;
    end
  endtask

  task automatic drive_req();
    for (int i = 0; i < NR; i++) begin
      if (xfer[i]) begin
        if (remain[i] > 0) begin remain[i]--; load(i); end
        else if (rand_req && $urandom_range(1) == 0) load(i);
        else req_valid[i] = 1'b0;
      end else if (rand_req) begin
        if (!req_valid[i] && $urandom_range(2) == 0) begin req_valid[i] = 1'b1; load(i); end
        else if (req_valid[i] && $urandom_range(19) == 0) req_valid[i] = 1'b0;
      end
    end
  endtask

  // One clock: check combinational ready, advance model at the edge,
  // check registered outputs, then drive the next inputs at negedge.
  task automatic tick();
    logic [NR-1:0] exp_ready, exp_resp;
    int w;
    #1;
    w = rr_pick(req_valid, m_last);
    exp_ready = (!m_busy && acc_ready && w >= 0) ? (NR'(1) << w) : '0;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    xfer = req_valid & req_ready;
    for (int i = 0; i < NR; i++) if (xfer[i]) grants.push_back(i);
    @(posedge clk);
    exp_resp = '0;
    if (!m_busy) begin
      if (acc_ready && w >= 0) begin
        m_busy = 1; m_presented = 1; m_owner = w; m_last = w;
        m_inst = req_inst[CW*w +: CW];
        m_rs1  = req_rs1[DW*w +: DW];
        m_rs2  = req_rs2[DW*w +: DW];
      end
    end else if (m_presented) begin
      if (!acc_ready) m_presented = 0;
    end else if (acc_ready) begin
      exp_resp = NR'(1) << m_owner;
      m_rd     = m_inst[6:2];
      m_busy   = 0;
    end
    #1;
    chk("acc_valid", 64'(acc_valid), 64'(m_presented));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("resp_valid", 64'(resp_valid), 64'(exp_resp));
    chk("resp_rd", 64'(resp_rd), 64'(m_rd));
    chk("acc_inst", 64'(acc_inst), 64'(m_inst));
    chk("acc_rs1", acc_rs1, m_rs1);
    chk("acc_rs2", acc_rs2, m_rs2);
    chk("err", 64'(err), 64'(0));
    for (int i = 0; i < NR; i++)
      if (resp_valid[i]) begin resp_cnt[i]++; rd_log.push_back(int'(resp_rd)); end
    @(negedge clk);
    drive_accel();
    drive_req();
  endtask

  task automatic run_idle(input string tag);
    int n;
    n = 0;
    while ((m_busy || req_valid != '0) && n < 300) begin tick(); n++; end
    tick();
    chk(tag, 64'(m_busy), 64'(0));
  endtask

  initial begin
    int exp_order [8];
    int n;
    req_inst = '0; req_rs1 = '0; req_rs2 = '0; req_valid = '0;
    acc_ready = 1'b1; fix_lat = 8; xfer = '0;
    apply_reset();

    // 1: single command from requester 0, accelerator takes 8 cycles
    start_req(0, 1);
    req_inst[CW*0 +: CW] = {7'h01, 5'd1, 5'd0, 3'b011, 5'd1, 2'b00};
    req_rs1[DW*0 +: DW]  = 64'h40000000_40000000;
    req_rs2[DW*0 +: DW]  = 64'h40000000_40000000;
    run_idle("t1_idle");
    chk("t1_ngrant", 64'(grants.size()), 64'(1));
    chk("t1_grant0", 64'(grants[0]), 64'(0));
    chk("t1_resp_cnt", 64'(resp_cnt[0]), 64'(1));
    chk("t1_rd", 64'(rd_log[0]), 64'(1));
    chk("t1_busy", 64'(busy), 64'(0));

    // 2: contention between 0 and 2 from reset
    apply_reset();
    fix_lat = 3;
    start_req(0, 1);
    start_req(2, 1);
    run_idle("t2_idle");
    chk("t2_ngrant", 64'(grants.size()), 64'(2));
    chk("t2_grant0", 64'(grants[0]), 64'(0));
    chk("t2_grant1", 64'(grants[1]), 64'(2));
    chk("t2_resp0", 64'(resp_cnt[0]), 64'(1));
    chk("t2_resp2", 64'(resp_cnt[2]), 64'(1));

    // 3: fairness, all four continuously for 8 commands
    apply_reset();
    fix_lat = 2;
    for (int i = 0; i < NR; i++) start_req(i, 2);
    run_idle("t3_idle");
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk("t3_ngrant", 64'(grants.size()), 64'(8));
    chk("t3_nresp", 64'(rd_log.size()), 64'(8));
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t3_grant%0d", k), 64'(grants[k]), 64'(exp_order[k]));
      chk($sformatf("t3_rd%0d", k), 64'(rd_log[k]), 64'(exp_order[k] + 1));
    end

    // 4: accelerator not ready for 10 cycles
    apply_reset();
    accel_auto = 0;
    acc_ready  = 1'b0;
    start_req(1, 1);
    for (int c = 0; c < 10; c++) tick();
    chk("t4_nogrant", 64'(grants.size()), 64'(0));
    chk("t4_acc_valid", 64'(acc_valid), 64'(0));
    acc_ready = 1'b1;
    tick();
    chk("t4_grant_now", 64'(grants.size()), 64'(1));
    chk("t4_grant_id", 64'(grants[0]), 64'(1));
    accel_auto = 1;
    fix_lat = 4;
    run_idle("t4_idle");

    // 5: reset while the command is in flight
    apply_reset();
    fix_lat = 20;
    start_req(2, 1);
    n = 0;
    while (!(m_busy && !m_presented) && n < 50) begin tick(); n++; end
    chk("t5_reached_busy", 64'(m_busy && !m_presented), 64'(1));
    tick();
    apply_reset();
    fix_lat = 3;
    start_req(3, 1);
    start_req(0, 1);
    run_idle("t5_idle");
    chk("t5_first_grant", 64'(grants[0]), 64'(0));
    chk("t5_resp2", 64'(resp_cnt[2]), 64'(0));

    // Randomized traffic with random latency and idle ready glitches
    apply_reset();
    rand_req = 1; rand_lat = 1; rand_glitch = 1;
    for (int c = 0; c < 1500; c++) tick();
    rand_req = 0;
    req_valid = '0;
    run_idle("rand_idle");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
